// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t   : memory-wait FSM states
//   fwd_t        : ALU operand forwarding select codes
//   reg_match    : "stage writes a non-zero register equal to src"
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } hz_state_t;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF  = 2'b00;
  localparam fwd_t FWD_WB  = 2'b01;
  localparam fwd_t FWD_MEM = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  function automatic logic reg_match(input logic       we,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   CLK   : clock
//   RST_N : async active-low reset, clears count
//   inc   : increment this cycle (held at all-ones once reached)
//   clear : synchronous clear, overrides inc
//   count : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use and
// branch stalls, branch flush, data-memory wait freeze with timeout error,
// and saturating stall/flush event counters.
//   CLK, RST_N                    : clock, async active-low reset
//   RsD/RtD, RsE/RtE              : source registers in decode / execute
//   WriteReg{E,M,W}, RegWrite{E,M,W}: destination register and write enable
//   MemtoRegE/M, MemWriteM        : load / store flags
//   BranchD, PCSrcD               : branch in decode, branch taken
//   MemReadyM                     : data memory completes this cycle
//   Stall{F,D,E,M}, Flush{D,E}    : pipeline register controls
//   Forward{A,B}E, Forward{A,B}D  : operand forwarding selects
//   MemErr                        : sticky memory timeout
//   StallCnt, FlushCnt            : saturating event counters
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  hz_state_t       state, state_n;
  logic [WW-1:0]   wait_cnt, wait_cnt_n;
  logic [WW-1:0]   wait_inc;
  logic            lwstall, branchstall, live_wait, memstall;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  assign wait_inc = wait_cnt + 1'b1;

  always_comb begin
    ForwardAE   = FWD_RF;
    ForwardBE   = FWD_RF;
    ForwardAD   = 1'b0;
    ForwardBD   = 1'b0;
    lwstall     = 1'b0;
    branchstall = 1'b0;
    live_wait   = 1'b0;
    memstall    = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    MemErr      = 1'b0;
    state_n     = state;
    wait_cnt_n  = wait_cnt;

    if (reg_match(RegWriteM, WriteRegM, RsE))      ForwardAE = FWD_MEM;
    else if (reg_match(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_WB;
    if (reg_match(RegWriteM, WriteRegM, RtE))      ForwardBE = FWD_MEM;
    else if (reg_match(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_WB;
    ForwardAD = reg_match(RegWriteM, WriteRegM, RsD);
    ForwardBD = reg_match(RegWriteM, WriteRegM, RtD);

    lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    branchstall = BranchD &&
                  (reg_match(RegWriteE, WriteRegE, RsD) ||
                   reg_match(RegWriteE, WriteRegE, RtD) ||
                   reg_match(MemtoRegM, WriteRegM, RsD) ||
                   reg_match(MemtoRegM, WriteRegM, RtD));
    live_wait = (MemtoRegM || MemWriteM) && !MemReadyM;
    memstall  = live_wait || (state == MEM_ERR);
    MemErr    = (state == MEM_ERR);

    // Freeze holds every stage and suppresses all flushes, so it overrides
    // the ordinary hazard stall/flush path entirely.
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else begin
      StallF = lwstall || branchstall;
      StallD = lwstall || branchstall;
      FlushE = lwstall || branchstall;
      FlushD = PCSrcD && !(lwstall || branchstall);
    end

    // The counter holds the number of cycles already waited, so the error
    // is raised on the edge where it would advance to TIMEOUT.
    unique case (state)
      RUN: begin
        if (live_wait) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_inc == WW'(TIMEOUT)) begin
          state_n    = MEM_ERR;
          wait_cnt_n = wait_inc;
        end else begin
          wait_cnt_n = wait_inc;
        end
      end
      MEM_ERR: state_n = MEM_ERR;
      default: begin
        state_n    = RUN;
        wait_cnt_n = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (StallF || StallD || StallE || StallM),
    .clear (1'b0),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (FlushD || FlushE),
    .clear (1'b0),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (counters narrowed to
// 5 bits so saturation is reachable).
module tb_hazard_controller;

  logic       CLK, RST_N;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, MemWriteM, BranchD, PCSrcD, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, MemErr;
  logic [4:0] StallCnt, FlushCnt;

  int checks   = 0;
  int failures = 0;

  hazard_controller #(.TIMEOUT(15), .CNT_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0; MemReadyM = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    #12;
    check("rst_stallf", 32'(StallF), 0);
    check("rst_stallcnt", 32'(StallCnt), 0);
    check("rst_flushcnt", 32'(FlushCnt), 0);
    check("rst_memerr", 32'(MemErr), 0);
    @(negedge CLK) RST_N = 1'b1;
    step();

    // forwarding
    RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd3; WriteRegW = 5'd3;
    RsE = 5'd3; RtE = 5'd3;
    #1;
    check("fwdAE_mem", 32'(ForwardAE), 2);
    check("fwdBE_mem", 32'(ForwardBE), 2);
    WriteRegM = 5'd0;
    #1;
    check("fwdAE_wb", 32'(ForwardAE), 1);
    RegWriteW = 1'b0;
    #1;
    check("fwdBE_rf", 32'(ForwardBE), 0);
    WriteRegM = 5'd4; RsD = 5'd4; RtD = 5'd6;
    #1;
    check("fwdAD", 32'(ForwardAD), 1);
    check("fwdBD", 32'(ForwardBD), 0);
    idle();

    // load-use
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    #1;
    check("lu_stallf", 32'(StallF), 1);
    check("lu_stalld", 32'(StallD), 1);
    check("lu_flushe", 32'(FlushE), 1);
    check("lu_stalle", 32'(StallE), 0);
    step();
    check("lu_stallcnt", 32'(StallCnt), 1);
    check("lu_flushcnt", 32'(FlushCnt), 1);
    idle();

    // freeze beats load-use and branch flush
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    MemtoRegM = 1'b1; MemReadyM = 1'b0; PCSrcD = 1'b1;
    #1;
    check("fz_stallf", 32'(StallF), 1);
    check("fz_stalld", 32'(StallD), 1);
    check("fz_stalle", 32'(StallE), 1);
    check("fz_stallm", 32'(StallM), 1);
    check("fz_flushe", 32'(FlushE), 0);
    check("fz_flushd", 32'(FlushD), 0);
    step();
    check("fz_stallcnt", 32'(StallCnt), 2);
    check("fz_flushcnt", 32'(FlushCnt), 1);
    idle();
    #1;
    check("fz_release", 32'(StallM), 0);
    step();
    check("fz_stallcnt2", 32'(StallCnt), 2);

    // branch flush vs branch stall
    BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd7; RtD = 5'd8;
    #1;
    check("br_flushd", 32'(FlushD), 1);
    check("br_stalld0", 32'(StallD), 0);
    step();
    check("br_flushcnt", 32'(FlushCnt), 2);
    RegWriteE = 1'b1; WriteRegE = 5'd7;
    #1;
    check("bs_flushd", 32'(FlushD), 0);
    check("bs_stalld", 32'(StallD), 1);
    check("bs_flushe", 32'(FlushE), 1);
    step();
    check("bs_stallcnt", 32'(StallCnt), 3);
    check("bs_flushcnt", 32'(FlushCnt), 3);
    idle();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0; RsD = 5'd0;
    #1;
    check("bs_r0", 32'(StallD), 0);
    idle();
    BranchD = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd9; RtD = 5'd9;
    #1;
    check("bs_load_m", 32'(StallD), 1);
    idle();
    MemtoRegE = 1'b1; RtE = 5'd0; RsD = 5'd0;
    #1;
    check("lu_r0", 32'(StallF), 0);
    idle();
    step();

    // MemReadyM arrives on the 15th wait cycle
    MemWriteM = 1'b1; MemReadyM = 1'b0;
    #1;
    check("to_live", 32'(StallM), 1);
    for (int i = 1; i <= 14; i++) step();
    MemReadyM = 1'b1;
    #1;
    check("to_ready_nostall", 32'(StallF), 0);
    step();
    idle();
    #1;
    check("to_ready_memerr", 32'(MemErr), 0);
    check("to_ready_run", 32'(StallF), 0);
    check("to_stallcnt", 32'(StallCnt), 17);

    // full timeout -> sticky error
    MemWriteM = 1'b1; MemReadyM = 1'b0;
    for (int i = 1; i <= 14; i++) step();
    check("err_not_yet", 32'(MemErr), 0);
    step();
    check("err_set", 32'(MemErr), 1);
    idle();
    PCSrcD = 1'b1;
    #1;
    check("err_freeze", 32'(StallE), 1);
    check("err_noflush", 32'(FlushD), 0);
    repeat (5) step();
    check("err_sticky", 32'(MemErr), 1);
    check("sat_stallcnt", 32'(StallCnt), 31);
    check("err_flushcnt", 32'(FlushCnt), 3);

    // async reset clears the error without a clock edge
    #2 RST_N = 1'b0;
    #1;
    check("rst_err_memerr", 32'(MemErr), 0);
    check("rst_err_cnt", 32'(StallCnt), 0);
    idle();
    @(negedge CLK) RST_N = 1'b1;
    step();

    // async reset in the middle of a wait
    MemWriteM = 1'b1; MemReadyM = 1'b0;
    step(); step(); step();
    check("mw_stallcnt", 32'(StallCnt), 3);
    #2 RST_N = 1'b0;
    #1;
    check("mw_rst_stallcnt", 32'(StallCnt), 0);
    check("mw_rst_flushcnt", 32'(FlushCnt), 0);
    check("mw_rst_memerr", 32'(MemErr), 0);
    MemReadyM = 1'b1;
    #1;
    check("mw_rst_stall", 32'(StallM), 0);
    @(negedge CLK) RST_N = 1'b1;
    step();
    check("mw_after_stallf", 32'(StallF), 0);
    check("mw_after_cnt", 32'(StallCnt), 0);
    MemReadyM = 1'b0;
    #1;
    check("mw_after_live", 32'(StallF), 1);
    MemReadyM = 1'b1;
    #1;
    check("mw_after_ready", 32'(StallF), 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
